// File: rtl/lsu_pkg.sv
// Shared types and helpers for load_store_unit: FSM states, RV64 funct3 codes,
// access sizes and byte-lane helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_RSV = 3'b111;

  // Byte-enable pattern of an access of the given size, anchored at lane 0.
  function automatic logic [7:0] lane_mask(input size_t s);
    case (s)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Offset bits that must stay as-is for an access of this size to be aligned.
  function automatic logic [2:0] align_mask(input size_t s);
    case (s)
      SZ_B:    return 3'b111;
      SZ_H:    return 3'b110;
      SZ_W:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic misaligned(input size_t s, input logic [2:0] off);
    return |(off & ~align_mask(s));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Datapath request/response and data-memory signals of load_store_unit.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        funct3;
  logic [63:0]       addr;
  logic [63:0]       wdata;
  logic              rsp_valid;
  logic [63:0]       rdata;
  logic              misalign_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  modport master (
    output req_valid, req_write, funct3, addr, wdata,
    input  req_ready, rsp_valid, rdata, misalign_err
  );

  modport slave (
    input  req_valid, req_write, funct3, addr, wdata, mem_rdata,
    output req_ready, rsp_valid, rdata, misalign_err, mem_addr, mem_wren, mem_wdata
  );

  modport memory (
    input  mem_addr, mem_wren, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_lane_shift.sv
// Combinational byte-lane logic: load extract + sign/zero extension, and
// narrow-store merge of new bytes into the word read from memory.
module lsu_lane_shift
  import lsu_pkg::*;
(
  input  size_t       size,
  input  logic        is_unsigned,
  input  logic [2:0]  offset,
  input  logic [63:0] word,
  input  logic [63:0] store_data,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  logic [63:0] shifted;
  logic [63:0] wshift;
  logic [7:0]  bmask;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_B:    load_data = is_unsigned ? {56'd0, shifted[7:0]}
                                       : {{56{shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = is_unsigned ? {48'd0, shifted[15:0]}
                                       : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    load_data = is_unsigned ? {32'd0, shifted[31:0]}
                                       : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    bmask  = lane_mask(size) << offset;
    wshift = store_data << {offset, 3'b000};
    merged = word;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bmask[i]) merged[i*8 +: 8] = wshift[i*8 +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: byte-lane loads with extension and read-modify-write
// narrow stores on a 64-bit-word memory. Build option: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  state_t            state;
  logic              a_write;
  logic [2:0]        a_f3;
  logic [2:0]        a_off_raw;
  logic [ADDR_W-1:0] a_word;
  logic [63:0]       a_wdata;
  logic [15:0]       cnt;
  logic [63:0]       rdata_q;
  logic [63:0]       mem_wdata_q;
  logic              err_q;

  logic              accept;
  logic              req_trap;
  size_t             req_size;
  size_t             a_size;
  logic [2:0]        a_off;
  logic [63:0]       load_data;
  logic [63:0]       merged;
  logic              unused_addr_hi;

  assign accept         = bus.req_valid && (state == ST_IDLE);
  assign req_size       = size_t'(bus.funct3[1:0]);
  assign a_size         = size_t'(a_f3[1:0]);
  assign unused_addr_hi = ^bus.addr[63:ADDR_W+3];

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_trap = misaligned(req_size, bus.addr[2:0]) ||
                    (!bus.req_write && bus.funct3 == F3_RSV);
  assign a_off    = a_off_raw;
`else
  // Misaligned offsets round down to the access size; funct3=111 decodes as ld.
  assign req_trap = 1'b0;
  assign a_off    = a_off_raw & align_mask(a_size);
`endif

  lsu_lane_shift u_lane (
    .size        (a_size),
    .is_unsigned (a_f3[2]),
    .offset      (a_off),
    .word        (bus.mem_rdata),
    .store_data  (a_wdata),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      a_write     <= 1'b0;
      a_f3        <= '0;
      a_off_raw   <= '0;
      a_word      <= '0;
      a_wdata     <= '0;
      cnt         <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_write   <= bus.req_write;
            a_f3      <= bus.funct3;
            a_off_raw <= bus.addr[2:0];
            a_word    <= bus.addr[ADDR_W+2:3];
            a_wdata   <= bus.wdata;
            cnt       <= 16'(MEM_LAT - 1);
            err_q     <= req_trap;
            if (req_trap) begin
              state <= ST_RESP;
            end else if (bus.req_write && req_size == SZ_D) begin
              mem_wdata_q <= bus.wdata;
              state       <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (cnt == '0) state <= ST_MERGE;
          else           cnt   <= cnt - 16'd1;
        end
        ST_MERGE: begin
          if (a_write) begin
            mem_wdata_q <= merged;
            state       <= ST_WRITE;
          end else begin
            rdata_q <= load_data;
            state   <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == ST_IDLE);
  assign bus.rsp_valid    = (state == ST_RESP);
  assign bus.rdata        = rdata_q;
  assign bus.misalign_err = (state == ST_RESP) && err_q;
  assign bus.mem_addr     = a_word;
  assign bus.mem_wren     = (state == ST_WRITE);
  assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, scoreboard queue and
// hand-written reset/abort sequences; works with or without LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned ML = 2;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] preset;
    logic [63:0] exp;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [63:0] rd;
    logic        err;
    int unsigned due;
    logic        wr;
    logic [7:0]  widx;
  } sb_t;

  localparam int NV = 19;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  sb_t         sb[$];
  vec_t        vecs [0:NV-1];
  logic [63:0] last_rdata;

  logic [63:0] mem     [0:(1<<AW)-1];
  logic [63:0] rd_pipe [0:ML-1];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [63:0] pl_data;

  load_store_unit_if #(.ADDR_W(AW)) bus ();

  load_store_unit #(.ADDR_W(AW), .MEM_LAT(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[ML-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [63:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = idx; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    sb_t         e;
    int unsigned wr_n = 0;
    int unsigned wr_cyc = 0;
    logic [7:0]  wr_idx = '0;
    logic        busy_ok = 1'b1;
    bit          done = 1'b0;
    for (int n = 0; n < 64 && !done; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.mem_wren) begin wr_n++; wr_cyc = cyc; wr_idx = bus.mem_addr; end
      if (bus.req_ready) busy_ok = 1'b0;
      if (bus.rsp_valid) done = 1'b1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: got no rsp_valid, expected one within 64 cycles", tag);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    check({tag, " rsp_cycle"}, 64'(cyc), 64'(e.due));
    check({tag, " rdata"}, bus.rdata, e.rd);
    check({tag, " misalign_err"}, 64'(bus.misalign_err), 64'(e.err));
    check({tag, " ready_low_busy"}, 64'(busy_ok), 64'd1);
    check({tag, " wren_count"}, 64'(wr_n), e.wr ? 64'd1 : 64'd0);
    if (e.wr) begin
      check({tag, " wren_cycle"}, 64'(wr_cyc), 64'(e.due - 1));
      check({tag, " wren_addr"}, 64'(wr_idx), 64'(e.widx));
    end
  endtask

  task automatic issue(input string tag, input logic w, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input int unsigned lat,
                       input logic [63:0] exp_rd, input logic exp_err, input logic exp_wr);
    sb_t e;
    @(negedge clk);
    check({tag, " ready_idle"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    e.rd = exp_rd; e.err = exp_err; e.due = cyc + lat; e.wr = exp_wr; e.widx = a[10:3];
    sb.push_back(e);
    @(negedge clk);
    // Scramble request fields after accept: the unit must use its latched copy.
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.funct3    = 3'($urandom_range(0, 7));
    bus.addr      = {$urandom, $urandom};
    bus.wdata     = {$urandom, $urandom};
    wait_rsp(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    bit          trap;
    int unsigned lat;
    logic [7:0]  idx;
    logic [63:0] exp_rd;
    logic        exp_wr;
    logic        wr_seen;
    logic        rsp_seen;

    vecs[0]  = '{1'b0, F3_B,  64'h00, 64'h0, 64'h00000000_800000F0, 64'hFFFFFFFF_FFFFFFF0, 1'b0};
    vecs[1]  = '{1'b0, F3_BU, 64'h00, 64'h0, 64'h00000000_800000F0, 64'h00000000_000000F0, 1'b0};
    vecs[2]  = '{1'b0, F3_H,  64'h02, 64'h0, 64'h00000000_800000F0, 64'hFFFFFFFF_FFFF8000, 1'b0};
    vecs[3]  = '{1'b0, F3_WU, 64'h00, 64'h0, 64'h00000000_800000F0, 64'h00000000_800000F0, 1'b0};
    vecs[4]  = '{1'b0, F3_W,  64'h00, 64'h0, 64'h00000000_800000F0, 64'hFFFFFFFF_800000F0, 1'b0};
    vecs[5]  = '{1'b0, F3_D,  64'h00, 64'h0, 64'h00000000_800000F0, 64'h00000000_800000F0, 1'b0};
    vecs[6]  = '{1'b0, F3_HU, 64'h02, 64'h0, 64'h00000000_800000F0, 64'h00000000_00008000, 1'b0};
    vecs[7]  = '{1'b0, F3_B,  64'h03, 64'h0, 64'h00000000_800000F0, 64'hFFFFFFFF_FFFFFF80, 1'b0};
    vecs[8]  = '{1'b0, F3_W,  64'h2C, 64'h0, 64'h81234567_89ABCDEF, 64'hFFFFFFFF_81234567, 1'b0};
    vecs[9]  = '{1'b0, F3_BU, 64'h2F, 64'h0, 64'h81234567_89ABCDEF, 64'h00000000_00000081, 1'b0};
    vecs[10] = '{1'b0, F3_H,  64'h2E, 64'h0, 64'h81234567_89ABCDEF, 64'hFFFFFFFF_FFFF8123, 1'b0};
    vecs[11] = '{1'b0, F3_D,  64'hFFFF0000_00000028, 64'h0, 64'h81234567_89ABCDEF, 64'h81234567_89ABCDEF, 1'b0};
    vecs[12] = '{1'b1, F3_B,  64'h03, 64'h00000000_000000AB, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_ABFFFFFF, 1'b0};
    vecs[13] = '{1'b1, F3_H,  64'h0E, 64'h00000000_1234BEEF, 64'h0, 64'hBEEF0000_00000000, 1'b0};
    vecs[14] = '{1'b1, F3_W,  64'h14, 64'hDEADBEEF_CAFEF00D, 64'h11111111_11111111, 64'hCAFEF00D_11111111, 1'b0};
    vecs[15] = '{1'b1, F3_D,  64'h10, 64'h11223344_55667788, 64'h0, 64'h11223344_55667788, 1'b0};
    vecs[16] = '{1'b1, F3_BU, 64'h21, 64'hAAAAAAAA_AAAAAA55, 64'h0, 64'h00000000_00005500, 1'b0};
    vecs[17] = '{1'b0, F3_W,  64'h06, 64'h0, 64'h77665544_33221100, 64'h00000000_77665544, 1'b1};
    vecs[18] = '{1'b0, F3_RSV, 64'h08, 64'h0, 64'h77665544_33221100, 64'h77665544_33221100, 1'b1};

    rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 64'(bus.req_ready), 64'd1);
    check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset mem_wren", 64'(bus.mem_wren), 64'd0);
    check("reset rdata", bus.rdata, 64'd0);
    check("reset misalign_err", 64'(bus.misalign_err), 64'd0);
    check("reset mem_addr", 64'(bus.mem_addr), 64'd0);
    check("reset mem_wdata", bus.mem_wdata, 64'd0);
    rst = 1'b1;
    last_rdata = '0;

    for (int i = 0; i < NV; i++) begin
      v    = vecs[i];
      idx  = v.addr[10:3];
      trap = TRAP && v.mis;
      if (trap)                            lat = 1;
      else if (v.w && v.f3[1:0] == 2'b11) lat = 2;
      else if (v.w)                        lat = ML + 3;
      else                                 lat = ML + 2;
      exp_wr = v.w && !trap;
      exp_rd = (v.w || trap) ? last_rdata : v.exp;
      preload(idx, v.preset);
      issue($sformatf("v%0d", i), v.w, v.f3, v.addr, v.wdata, lat, exp_rd, trap, exp_wr);
      check($sformatf("v%0d mem_word", i), mem[idx], exp_wr ? v.exp : v.preset);
      if (!v.w && !trap) last_rdata = v.exp;
    end

    // Abort a sw during READ: no write may reach memory, unit restarts idle.
    preload(8'd3, 64'hA5A55A5A_0F0FF0F0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.funct3 = F3_W;
    bus.addr = 64'h18; bus.wdata = 64'h0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort busy_in_read", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    wr_seen = 1'b0; rsp_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_wren) wr_seen = 1'b1;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_wren) wr_seen = 1'b1;
      if (bus.rsp_valid) rsp_seen = 1'b1;
    end
    check("abort no_wren", 64'(wr_seen), 64'd0);
    check("abort no_rsp", 64'(rsp_seen), 64'd0);
    check("abort ready", 64'(bus.req_ready), 64'd1);
    check("abort rdata_cleared", bus.rdata, 64'd0);
    check("abort word_kept", mem[3], 64'hA5A55A5A_0F0FF0F0);
    last_rdata = '0;
    issue("after_abort ld", 1'b0, F3_D, 64'h18, 64'h0, ML + 2, 64'hA5A55A5A_0F0FF0F0, 1'b0, 1'b0);
    issue("after_abort lh", 1'b0, F3_H, 64'h1E, 64'h0, ML + 2, 64'hFFFFFFFF_FFFFA5A5, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
